// File: rtl/nx_roreg_read_arbiter.sv
// -----------------------------------------------------------------------------
// nx_roreg_read_arbiter
//
// This block shares one read-only register array among N_REQ requesters.
// A round-robin arbiter accepts at most one read in each cycle. The response
// comes back exactly one cycle after acceptance. Reads outside the array
// return zero data with rsp_err set, and each one is counted in a saturating
// error counter.
//
// Parameters
//   N_REQ        number of requesters (2..8)
//   N_ENTRIES    number of entries in the shared array
//   N_DATA_BITS  width of each entry
//   N_ADDR_BITS  width of each requester address
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   arb_en    grant enable; no new acceptance while low
//   req_vld   per-requester read request valid
//   req_addr  per-requester address; requester i uses slice i
//   req_rdy   per-requester grant (combinational, at most one bit set)
//   rsp_vld   per-requester response valid, one cycle after acceptance
//   rsp_dat   shared response data (zero when no response is valid)
//   rsp_err   response address was out of range
//   err_cnt   saturating count of accepted out-of-range reads
//   cnt_clr   synchronous clear of err_cnt; takes priority over increment
//   mem_a     flattened array contents; entry e uses slice e
// -----------------------------------------------------------------------------
module nx_roreg_read_arbiter #(
    parameter int N_REQ       = 4,
    parameter int N_ENTRIES   = 16,
    parameter int N_DATA_BITS = 32,
    parameter int N_ADDR_BITS = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             arb_en,
    input  logic [N_REQ-1:0]                 req_vld,
    input  logic [N_REQ*N_ADDR_BITS-1:0]     req_addr,
    output logic [N_REQ-1:0]                 req_rdy,
    output logic [N_REQ-1:0]                 rsp_vld,
    output logic [N_DATA_BITS-1:0]           rsp_dat,
    output logic                             rsp_err,
    output logic [15:0]                      err_cnt,
    input  logic                             cnt_clr,
    input  logic [N_ENTRIES*N_DATA_BITS-1:0] mem_a
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    // The comparison width is at least 32 bits so that N_ENTRIES is never
    // truncated. It is also at least N_ADDR_BITS so that the address is never
    // truncated.
    localparam int CMP_W = (N_ADDR_BITS > 32) ? N_ADDR_BITS : 32;

    logic [PTR_W-1:0]       r_rr_ptr;
    logic [N_REQ-1:0]       r_rsp_vld;
    logic [N_DATA_BITS-1:0] r_rsp_dat;
    logic                   r_rsp_err;
    logic [15:0]            r_err_cnt;

    logic                   w_gnt_any;
    logic [PTR_W-1:0]       w_gnt_idx;
    logic [PTR_W-1:0]       w_scan;
    logic [N_REQ-1:0]       w_gnt_oh;
    logic                   w_accept;
    logic [N_ADDR_BITS-1:0] w_addr;
    logic [CMP_W-1:0]       w_addr_cmp;
    logic                   w_in_range;
    logic [IDX_W-1:0]       w_ent_idx;
    logic [N_DATA_BITS-1:0] w_ent_dat;
    logic [PTR_W-1:0]       w_ptr_nxt;

    // Round-robin search.
    // The loop scans from the farthest slot back towards rr_ptr, so the last
    // hit it records is the nearest valid requester at or after rr_ptr.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_scan = PTR_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (req_vld[w_scan]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan;
            end
        end
    end

    always_comb begin
        w_gnt_oh = '0;
        for (int j = 0; j < N_REQ; j++) begin
            w_gnt_oh[j] = w_gnt_any && (w_gnt_idx == PTR_W'(j));
        end
    end

    assign w_accept = arb_en && w_gnt_any;
    assign req_rdy  = (arb_en && rst_n) ? w_gnt_oh : '0;

    // Look up the data for the granted address.
    assign w_addr     = req_addr[int'(w_gnt_idx)*N_ADDR_BITS +: N_ADDR_BITS];
    assign w_addr_cmp = CMP_W'(w_addr);
    assign w_in_range = (w_addr_cmp < CMP_W'(N_ENTRIES));
    assign w_ent_idx  = w_addr_cmp[IDX_W-1:0];
    // The in-range mux also hides a part-select that points past the array
    // when N_ENTRIES is not a power of two.
    assign w_ent_dat  = w_in_range ? mem_a[int'(w_ent_idx)*N_DATA_BITS +: N_DATA_BITS] : '0;

    assign w_ptr_nxt  = (w_gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);

    // Response registers.
    // They load a fresh value on every edge. An idle cycle loads zeros, so
    // rsp_dat and rsp_err read zero whenever no response is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so that every register samples pre-edge values.
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_rsp_vld <= '0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_vld <= w_accept ? w_gnt_oh : '0;
            r_rsp_dat <= (w_accept && w_in_range) ? w_ent_dat : '0;
            r_rsp_err <= w_accept && !w_in_range;
            if (w_accept) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    // Error counter.
    // A clear wins over an increment that lands in the same cycle.
    // Once the count reaches 16'hFFFF it stays there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (cnt_clr) begin
            r_err_cnt <= '0;
        end else if (w_accept && !w_in_range && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign rsp_vld = r_rsp_vld;
    assign rsp_dat = r_rsp_dat;
    assign rsp_err = r_rsp_err;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_nx_roreg_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nx_roreg_read_arbiter
//
// Directed bench for nx_roreg_read_arbiter with the default parameters.
//
// Array contents: entry e holds 32'hA500_0000 | e, except entry 5, which
// holds 32'hDEADBEEF.
//
// Each table row is driven on a falling edge. req_rdy is checked before the
// next rising edge. The registered outputs are checked 1 time unit after that
// rising edge. Hand-written sequences after the table cover enable drop,
// counter saturation and reset in the middle of traffic.
// -----------------------------------------------------------------------------
module tb_nx_roreg_read_arbiter;

    localparam int NR = 4;
    localparam int NE = 16;
    localparam int DW = 32;
    localparam int AW = 16;

    logic              clk;
    logic              rst_n;
    logic              arb_en;
    logic [NR-1:0]     req_vld;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_rdy;
    logic [NR-1:0]     rsp_vld;
    logic [DW-1:0]     rsp_dat;
    logic              rsp_err;
    logic [15:0]       err_cnt;
    logic              cnt_clr;
    logic [NE*DW-1:0]  mem_a;

    int n_tests = 0;
    int n_fail  = 0;

    nx_roreg_read_arbiter #(
        .N_REQ       (NR),
        .N_ENTRIES   (NE),
        .N_DATA_BITS (DW),
        .N_ADDR_BITS (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arb_en   (arb_en),
        .req_vld  (req_vld),
        .req_addr (req_addr),
        .req_rdy  (req_rdy),
        .rsp_vld  (rsp_vld),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .err_cnt  (err_cnt),
        .cnt_clr  (cnt_clr),
        .mem_a    (mem_a)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        en;
        logic [3:0]  vld;
        logic        clr;
        logic [63:0] addr;   // {a3, a2, a1, a0}
        logic [3:0]  rdy;    // expected before the edge
        logic [3:0]  rsp;    // expected after the edge
        logic [31:0] dat;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] vld, input logic clr, input logic [63:0] addr);
        @(negedge clk);
        arb_en   = en;
        req_vld  = vld;
        cnt_clr  = clr;
        req_addr = addr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ad(input logic [15:0] a3, input logic [15:0] a2,
                                       input logic [15:0] a1, input logic [15:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    initial begin
        logic [63:0] da;
        da = ad(16'd3, 16'd2, 16'd1, 16'd0);

        for (int e = 0; e < NE; e++) begin
            mem_a[e*DW +: DW] = 32'hA500_0000 | 32'(e);
        end
        mem_a[5*DW +: DW] = 32'hDEAD_BEEF;

        // Comments give the pointer before -> after each row.
        // Round-robin sweep 0,1,2,3,0 (ptr 0 -> 1 -> 2 -> 3 -> 0 -> 1).
        vecs[0]  = '{1'b1, 4'hF, 1'b0, da, 4'b0001, 4'b0001, 32'hA500_0000, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 4'hF, 1'b0, da, 4'b0010, 4'b0010, 32'hA500_0001, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 4'hF, 1'b0, da, 4'b0100, 4'b0100, 32'hA500_0002, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 4'hF, 1'b0, da, 4'b1000, 4'b1000, 32'hA500_0003, 1'b0, 16'd0};
        vecs[4]  = '{1'b1, 4'hF, 1'b0, da, 4'b0001, 4'b0001, 32'hA500_0000, 1'b0, 16'd0};
        // Idle: no grant, zero outputs, ptr stays 1.
        vecs[5]  = '{1'b1, 4'h0, 1'b0, da, 4'b0000, 4'b0000, 32'h0, 1'b0, 16'd0};
        // Only req0 valid with ptr=1: wraps around to 0 (ptr -> 1).
        vecs[6]  = '{1'b1, 4'b0001, 1'b0, da, 4'b0001, 4'b0001, 32'hA500_0000, 1'b0, 16'd0};
        // ptr=1, reqs 0 and 2 valid: req2 reads entry 5 (ptr -> 3).
        vecs[7]  = '{1'b1, 4'b0101, 1'b0, ad(16'd3, 16'd5, 16'd1, 16'd0),
                     4'b0100, 4'b0100, 32'hDEAD_BEEF, 1'b0, 16'd0};
        // ptr=3, reqs 0 and 1 valid: req0 wins (ptr -> 1).
        vecs[8]  = '{1'b1, 4'b0011, 1'b0, ad(16'd3, 16'd2, 16'h0010, 16'd0),
                     4'b0001, 4'b0001, 32'hA500_0000, 1'b0, 16'd0};
        // req1 reads address 0x0010: out of range (ptr -> 2).
        vecs[9]  = '{1'b1, 4'b0010, 1'b0, ad(16'd3, 16'd2, 16'h0010, 16'd0),
                     4'b0010, 4'b0010, 32'h0, 1'b1, 16'd1};
        // 0xFFFF: truncation would give entry 15.
        vecs[10] = '{1'b1, 4'b0010, 1'b0, ad(16'd3, 16'd2, 16'hFFFF, 16'd0),
                     4'b0010, 4'b0010, 32'h0, 1'b1, 16'd2};
        // 0x0105: truncation would give entry 5.
        vecs[11] = '{1'b1, 4'b0010, 1'b0, ad(16'd3, 16'd2, 16'h0105, 16'd0),
                     4'b0010, 4'b0010, 32'h0, 1'b1, 16'd3};
        // Disabled: no grant, ptr stays 2.
        vecs[12] = '{1'b0, 4'hF, 1'b0, da, 4'b0000, 4'b0000, 32'h0, 1'b0, 16'd3};
        // Plain clear.
        vecs[13] = '{1'b0, 4'h0, 1'b1, da, 4'b0000, 4'b0000, 32'h0, 1'b0, 16'd0};
        // Clear together with an error acceptance: clear wins (ptr 2 -> 2).
        vecs[14] = '{1'b1, 4'b0010, 1'b1, ad(16'd3, 16'd2, 16'h0010, 16'd0),
                     4'b0010, 4'b0010, 32'h0, 1'b1, 16'd0};
        // ptr=2, only req3 valid: reads the last entry, 15 (ptr -> 0).
        vecs[15] = '{1'b1, 4'b1000, 1'b0, ad(16'd15, 16'd2, 16'd1, 16'd0),
                     4'b1000, 4'b1000, 32'hA500_000F, 1'b0, 16'd0};

        // Reset state.
        rst_n    = 1'b0;
        arb_en   = 1'b1;
        req_vld  = 4'hF;
        cnt_clr  = 1'b0;
        req_addr = da;
        #2;
        check("reset req_rdy", 64'(req_rdy), 64'h0);
        check("reset rsp_vld", 64'(rsp_vld), 64'h0);
        check("reset rsp_dat", 64'(rsp_dat), 64'h0);
        check("reset rsp_err", 64'(rsp_err), 64'h0);
        check("reset err_cnt", 64'(err_cnt), 64'h0);
        drive(1'b0, 4'h0, 1'b0, da);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].en, vecs[i].vld, vecs[i].clr, vecs[i].addr);
            check($sformatf("v%0d req_rdy", i), 64'(req_rdy), 64'(vecs[i].rdy));
            tick();
            check($sformatf("v%0d rsp_vld", i), 64'(rsp_vld), 64'(vecs[i].rsp));
            check($sformatf("v%0d rsp_dat", i), 64'(rsp_dat), 64'(vecs[i].dat));
            check($sformatf("v%0d rsp_err", i), 64'(rsp_err), 64'(vecs[i].err));
            check($sformatf("v%0d err_cnt", i), 64'(err_cnt), 64'(vecs[i].cnt));
        end

        // Enable drop right after req3 is granted (ptr=0 -> 0).
        drive(1'b1, 4'b1000, 1'b0, da);
        check("en grant3 rdy", 64'(req_rdy), 64'b1000);
        tick();
        drive(1'b0, 4'hF, 1'b0, da);
        check("en off rdy", 64'(req_rdy), 64'h0);
        check("en inflight rsp_vld", 64'(rsp_vld), 64'b1000);
        check("en inflight rsp_dat", 64'(rsp_dat), 64'hA500_0003);
        tick();
        check("en off rsp_vld", 64'(rsp_vld), 64'h0);
        drive(1'b1, 4'hF, 1'b0, da);
        check("en reenable rdy", 64'(req_rdy), 64'b0001);
        tick();
        check("en reenable rsp_vld", 64'(rsp_vld), 64'b0001);

        // Saturation of the error counter (ptr=1, req1 always wins).
        drive(1'b0, 4'h0, 1'b1, da);
        tick();
        check("sat clear", 64'(err_cnt), 64'h0);
        drive(1'b1, 4'b0010, 1'b0, ad(16'd3, 16'd2, 16'h0010, 16'd0));
        repeat (65534) tick();
        check("sat FFFE", 64'(err_cnt), 64'hFFFE);
        tick();
        check("sat FFFF", 64'(err_cnt), 64'hFFFF);
        tick();
        check("sat hold", 64'(err_cnt), 64'hFFFF);
        check("sat rsp_err", 64'(rsp_err), 64'h1);

        // Reset in the middle of traffic: grant req2 (ptr 2 -> 3), then reset.
        drive(1'b1, 4'b0100, 1'b0, ad(16'd3, 16'd5, 16'd1, 16'd0));
        check("rst pre grant rdy", 64'(req_rdy), 64'b0100);
        tick();
        check("rst pre rsp_dat", 64'(rsp_dat), 64'hDEAD_BEEF);
        #1 rst_n = 1'b0;
        #1;
        check("rst mid rsp_vld", 64'(rsp_vld), 64'h0);
        check("rst mid rsp_dat", 64'(rsp_dat), 64'h0);
        check("rst mid rsp_err", 64'(rsp_err), 64'h0);
        check("rst mid err_cnt", 64'(err_cnt), 64'h0);
        drive(1'b1, 4'hF, 1'b0, da);
        check("rst mid req_rdy", 64'(req_rdy), 64'h0);
        tick();
        check("rst held rsp_vld", 64'(rsp_vld), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst release rdy", 64'(req_rdy), 64'b0001);
        tick();
        check("rst release rsp_vld", 64'(rsp_vld), 64'b0001);
        check("rst release rsp_dat", 64'(rsp_dat), 64'hA500_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nx_roreg_read_arbiter.md
NX_ROREG_READ_ARBITER -- requirements
Module: nx_roreg_read_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of read requesters; legal range 2..8.
REQ-002 Parameter N_ENTRIES, default 16: number of entries in the shared read-only register array.
REQ-003 Parameter N_DATA_BITS, default 32: width of each entry.
REQ-004 Parameter N_ADDR_BITS, default 16: width of each requester address.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 arb_en  input  1  grant enable; when low, no new request is accepted.
REQ-008 req_vld  input  N_REQ  per-requester read request valid.
REQ-009 req_addr  input  N_REQ x N_ADDR_BITS  per-requester entry address.
REQ-010 req_rdy  output  N_REQ  per-requester grant; at most one bit set.
REQ-011 rsp_vld  output  N_REQ  per-requester response valid; one-hot or zero.
REQ-012 rsp_dat  output  N_DATA_BITS  response data, shared by all requesters.
REQ-013 rsp_err  output  1  response address out of range.
REQ-014 err_cnt  output  16  saturating count of out-of-range accesses.
REQ-015 cnt_clr  input  1  synchronous clear of err_cnt.
REQ-016 mem_a  input  N_ENTRIES x N_DATA_BITS  flattened contents of the shared register array.

Function
REQ-017 A request is accepted in a cycle only when req_vld[i] and req_rdy[i] are both high, so at most one acceptance occurs per cycle.
REQ-018 req_rdy SHALL be combinational from arb_en, req_vld and the round-robin pointer rr_ptr; it is all-zero when arb_en=0 or req_vld=0.
REQ-019 Grant order: the first requester with req_vld set, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
REQ-020 On acceptance by requester g, rr_ptr becomes (g+1) mod N_REQ; otherwise rr_ptr holds its value.
REQ-021 Latency: rsp_vld[g] is 1 exactly one cycle after acceptance, for exactly one cycle; there is no response backpressure.
REQ-022 Response data, registered at acceptance:
- If addr < N_ENTRIES: rsp_dat = mem_a[addr] and rsp_err = 0.
- Otherwise: rsp_dat = 0 and rsp_err = 1.
REQ-023 Address comparison is unsigned over the full N_ADDR_BITS; the address is never truncated.
REQ-024 When no response is valid, rsp_dat = 0 and rsp_err = 0.
REQ-025 Back-to-back acceptances are supported every cycle, giving full throughput.
REQ-026 err_cnt increments by 1 on each accepted out-of-range request and saturates at 16'hFFFF.
REQ-027 cnt_clr takes priority over increment: when both occur in the same cycle, err_cnt becomes 0.
REQ-028 When arb_en falls, a response already in flight is still delivered on the next cycle, and rr_ptr is preserved.
REQ-029 A requester SHALL hold req_vld and req_addr stable until it is granted; the arbiter does not check this.

Reset
REQ-030 Asynchronous assertion of rst_n clears the following: rr_ptr = 0, rsp_vld = 0, rsp_dat = 0, rsp_err = 0, err_cnt = 0.
REQ-031 A response in flight when reset asserts is discarded and never presented.
REQ-032 req_rdy is 0 while rst_n is low.

Verification
REQ-033 Round-robin: N_REQ=4, all req_vld=1 continuously with arb_en=1 after reset -> grants in order 0,1,2,3,0,...; each rsp_vld[i] appears one cycle after its grant.
REQ-034 Data path: mem_a[5]=32'hDEADBEEF, requester 2 reads addr 5 -> rsp_vld=4'b0100 next cycle, rsp_dat=32'hDEADBEEF, rsp_err=0.
REQ-035 Out of range: requester 1 reads addr 16'h0010 with N_ENTRIES=16 -> rsp_dat=0, rsp_err=1, err_cnt=1. With err_cnt forced to 16'hFFFF, another error leaves it at 16'hFFFF.
REQ-036 Clear versus increment: cnt_clr=1 in the same cycle as an out-of-range acceptance -> err_cnt=0.
REQ-037 Enable: arb_en drops the cycle after requester 3 is granted -> its response is still delivered, no further grants occur, and rr_ptr remains 0 on re-enable.
REQ-038 Reset mid-operation: rst_n asserted the cycle after a grant -> no rsp_vld, all outputs 0, and the first grant after release goes to requester 0.
